// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: imem req/gnt/rvalid channel, execute redirect, and decode valid/ready.
// master = fetch_unit side, slave = memory/execute/decode environment side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fetch_misalign_o;

  modport master (
    output imem_req, imem_addr, instr_valid_o, instr_o, pc_o, fetch_misalign_o,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid_o, instr_o, pc_o, fetch_misalign_o,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: gnt N -> rvalid N+1 -> instr_valid_o N+2; requests stop once buffer+in-flight fill FIFO_DEPTH.
// `FETCH_MISALIGN_TRAP_EN: misaligned redirect sets a sticky flag and halts fetch until rst.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_deliver_pc;
  logic [31:0]   r_pc_last;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [31:0]   r_instr_mem [FIFO_DEPTH];
  logic [31:0]   r_pc_mem    [FIFO_DEPTH];

  logic          w_redirect;
  logic          w_misalign_redir;
  logic [31:0]   w_target;
  logic          w_req;
  logic          w_valid;
  logic [OW-1:0] w_occ;
  logic          w_grant;
  logic          w_rsp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign w_redirect = (r_state == S_RUN) && bus.redirect_valid;
  assign w_target   = {bus.redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_misalign_redir = w_redirect && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_misalign_redir) begin
      r_misalign <= 1'b1;
    end
  end

  assign bus.fetch_misalign_o = r_misalign;
`else
  logic w_unused_lsb;

  assign w_misalign_redir     = 1'b0;
  assign w_unused_lsb         = ^bus.redirect_pc[1:0];
  assign bus.fetch_misalign_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (w_misalign_redir) w_state_nxt = S_HALT;
      default: w_state_nxt = r_state;
    endcase
  end

  // A pop this cycle frees its slot before any new response can land, which keeps streaming bubble-free.
  always_comb begin
    w_valid = (r_state == S_RUN) && (r_count != '0);
    w_occ   = {1'b0, r_outst} + {1'b0, r_count} - OW'(w_valid && bus.dec_ready);
    w_req   = (r_state == S_RUN) && !bus.redirect_valid && (w_occ < OW'(FIFO_DEPTH));
  end

  assign w_grant = w_req && bus.imem_gnt;
  assign w_rsp   = bus.imem_rvalid && (r_outst != '0);
  assign w_drop  = w_rsp && (r_drop_cnt != '0);
  assign w_push  = w_rsp && !w_drop && !w_redirect;
  assign w_pop   = w_valid && bus.dec_ready && !w_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_deliver_pc <= RESET_PC;
      r_pc_last    <= RESET_PC;
      r_outst      <= '0;
      r_drop_cnt   <= '0;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
    end else begin
      if (w_redirect) begin
        r_fetch_pc   <= w_target;
        r_deliver_pc <= w_target;
        r_drop_cnt   <= r_outst - CW'(w_rsp);
        r_count      <= '0;
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_push) begin
          r_wr_ptr     <= ptr_inc(r_wr_ptr);
          r_deliver_pc <= r_deliver_pc + 32'd4;
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
      r_outst <= r_outst + CW'(w_grant) - CW'(w_rsp);
      if (w_valid) begin
        r_pc_last <= r_pc_mem[r_rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= bus.imem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_deliver_pc;
    end
  end

  assign bus.imem_req      = w_req;
  assign bus.imem_addr     = r_fetch_pc;
  assign bus.instr_valid_o = w_valid;
  assign bus.instr_o       = w_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
  assign bus.pc_o          = w_valid ? r_pc_mem[r_rd_ptr] : r_pc_last;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order 1-cycle imem model, delivery monitor, hand-computed expectations.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if bus();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_vec   = 0;
  int          n_bad   = 0;
  int          n_grant = 0;
  bit          rsp_en  = 1'b1;
  logic [31:0] mem_q   [$];
  logic [31:0] dlv_pc  [$];
  logic [31:0] dlv_ins [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Memory: answers each grant exactly one cycle later, in order, while rsp_en is set.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      mem_q.delete();
      bus.imem_rvalid = 1'b0;
    end else begin
      if (rsp_en && mem_q.size() > 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(mem_q.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
      if (bus.imem_req && bus.imem_gnt) mem_q.push_back(bus.imem_addr);
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (bus.imem_req && bus.imem_gnt) n_grant++;
      if (bus.instr_valid_o && bus.dec_ready && !bus.redirect_valid) begin
        dlv_pc.push_back(bus.pc_o);
        dlv_ins.push_back(bus.instr_o);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dlv_pc.delete();
    dlv_ins.delete();
    n_grant = 0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    dlv_pc.delete();
    dlv_ins.delete();
    #1;
    chk("redir_no_req", bus.imem_req, 32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_dlv(input string tag, input int n, input int budget);
    int k = 0;
    while (dlv_pc.size() < n && k < budget) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk(tag, 32'(dlv_pc.size() >= n), 32'd1);
  endtask

  initial begin
    bus.imem_gnt       = 1'b1;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req",   bus.imem_req,         32'd0);
    chk("rst_addr",  bus.imem_addr,        32'h8000_0000);
    chk("rst_vld",   bus.instr_valid_o,    32'd0);
    chk("rst_instr", bus.instr_o,          32'h0000_0013);
    chk("rst_pc",    bus.pc_o,             32'h8000_0000);
    chk("rst_mis",   bus.fetch_misalign_o, 32'd0);

    // Streaming: addresses advance every cycle, pc_o lags imem_addr by two cycles.
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      chk("strm_req",  bus.imem_req,      32'd1);
      chk("strm_addr", bus.imem_addr,     32'h8000_0000 + 32'(4 * (c - 1)));
      chk("strm_vld",  bus.instr_valid_o, 32'(c >= 3));
      if (c >= 3) begin
        chk("strm_pc",  bus.pc_o,    32'h8000_0000 + 32'(4 * (c - 3)));
        chk("strm_ins", bus.instr_o, mem_word(32'h8000_0000 + 32'(4 * (c - 3))));
      end
    end

    // Decode stall: only FIFO_DEPTH requests go out, then everything drains in order.
    bus.dec_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    #1;
    chk("bp_grants", 32'(n_grant),     32'd2);
    chk("bp_req",    bus.imem_req,      32'd0);
    chk("bp_vld",    bus.instr_valid_o, 32'd1);
    chk("bp_pc",     bus.pc_o,          32'h8000_0000);
    chk("bp_ins",    bus.instr_o,       32'hDA5A_5A5A);
    @(negedge clk);
    bus.dec_ready = 1'b1;
    dlv_pc.delete();
    dlv_ins.delete();
    wait_dlv("bp_dlv_cnt", 4, 40);
    if (dlv_pc.size() >= 4) begin
      chk("bp_dlv0", dlv_pc[0], 32'h8000_0000);
      chk("bp_dlv1", dlv_pc[1], 32'h8000_0004);
      chk("bp_dlv2", dlv_pc[2], 32'h8000_0008);
      chk("bp_dlv3", dlv_pc[3], 32'h8000_000C);
      chk("bp_ins3", dlv_ins[3], 32'hDA5A_5A56);
    end

    // Redirect with two responses still in flight: both must be dropped.
    rsp_en = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    #1;
    chk("fl_grants", 32'(n_grant),     32'd2);
    chk("fl_req",    bus.imem_req,      32'd0);
    chk("fl_vld",    bus.instr_valid_o, 32'd0);
    redirect_to(32'h8000_0100);
    rsp_en = 1'b1;
    wait_dlv("fl_dlv_cnt", 2, 40);
    if (dlv_pc.size() >= 2) begin
      chk("fl_pc0",  dlv_pc[0],  32'h8000_0100);
      chk("fl_ins0", dlv_ins[0], 32'hDA5A_5B5A);
      chk("fl_pc1",  dlv_pc[1],  32'h8000_0104);
    end

    // Redirect coinciding with a pop and an rvalid: the arriving word is the only in-flight one.
    do_reset();
    repeat (5) @(negedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0200;
    dlv_pc.delete();
    dlv_ins.delete();
    #1;
    chk("rp_vld_pre", bus.instr_valid_o, 32'd1);
    chk("rp_pc_pre",  bus.pc_o,          32'h8000_000C);
    chk("rp_req",     bus.imem_req,      32'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    chk("rp_flush_vld", bus.instr_valid_o, 32'd0);
    chk("rp_flush_ins", bus.instr_o,       32'h0000_0013);
    chk("rp_hold_pc",   bus.pc_o,          32'h8000_000C);
    chk("rp_new_addr",  bus.imem_addr,     32'h8000_0200);
    wait_dlv("rp_dlv_cnt", 1, 20);
    if (dlv_pc.size() >= 1) begin
      chk("rp_pc0",  dlv_pc[0],  32'h8000_0200);
      chk("rp_ins0", dlv_ins[0], 32'hDA5A_585A);
    end

    // Address wrap at the top of the 32-bit space.
    do_reset();
    repeat (4) @(negedge clk);
    redirect_to(32'hFFFF_FFFC);
    #1;
    chk("wr_req",   bus.imem_req,  32'd1);
    chk("wr_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    chk("wr_addr1", bus.imem_addr, 32'h0000_0000);
    wait_dlv("wr_dlv_cnt", 2, 20);
    if (dlv_pc.size() >= 2) begin
      chk("wr_pc0",  dlv_pc[0],  32'hFFFF_FFFC);
      chk("wr_ins0", dlv_ins[0], 32'hA5A5_A5A6);
      chk("wr_pc1",  dlv_pc[1],  32'h0000_0000);
      chk("wr_ins1", dlv_ins[1], 32'h5A5A_5A5A);
    end

    // Misaligned redirect target.
    do_reset();
    repeat (4) @(negedge clk);
    redirect_to(32'h8000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("ma_flag", bus.fetch_misalign_o, 32'd1);
      chk("ma_req",  bus.imem_req,         32'd0);
      chk("ma_vld",  bus.instr_valid_o,    32'd0);
      @(negedge clk);
    end
    do_reset();
    #1;
    chk("ma_rst_flag", bus.fetch_misalign_o, 32'd0);
    @(negedge clk);
    #1;
    chk("ma_rst_req", bus.imem_req, 32'd1);
`else
    #1;
    chk("ma_req",  bus.imem_req,         32'd1);
    chk("ma_addr", bus.imem_addr,        32'h8000_0100);
    chk("ma_flag", bus.fetch_misalign_o, 32'd0);
    wait_dlv("ma_dlv_cnt", 1, 20);
    if (dlv_pc.size() >= 1) begin
      chk("ma_pc0",  dlv_pc[0],  32'h8000_0100);
      chk("ma_ins0", dlv_ins[0], 32'hDA5A_5B5A);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time limit, %0d miscompares so far", n_bad);
    $fatal(1);
  end
endmodule
